// File: rtl/gcd_arbiter.sv
// gcd_arbiter: one shared subtractive GCD engine behind a round-robin arbiter.
// NREQ requesters offer operand pairs over valid/ready. One request is in
// flight at a time. Each result goes out on one response channel, tagged
// with the index of the requester that issued it.
//
// Optional feature, enabled by defining GCD_ARB_STEP_CNT_EN:
//   adds the rsp_cycles output, which reports the number of subtraction
//   steps taken for the returned result (saturating at all-ones).

module gcd_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_gcd,
    output logic [IDW-1:0]        rsp_id,
`ifdef GCD_ARB_STEP_CNT_EN
    output logic [WIDTH-1:0]      rsp_cycles,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Datapath and arbitration state
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] result_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   ptr_reg;

    // Per-requester operand views, unpacked from the flat buses
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    // Round-robin search helpers
    logic [NREQ-1:0]  ptr_mask;
    logic [NREQ-1:0]  masked_valid;
    logic [NREQ-1:0]  grant_onehot;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;
    logic             any_valid;
    logic             grant_fire;

    // CALC step decode
    logic             calc_end;
    logic             x_gt_y;
    logic [WIDTH-1:0] calc_result;

    genvar gi;

    // Split the packed operand buses into one slot per requester
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Mask of requesters at or above the pointer: the "upper" search window
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign ptr_mask[gi] = (IDW'(gi) >= ptr_reg);
        end
    endgenerate

    assign masked_valid = req_valid & ptr_mask;
    assign any_valid    = |req_valid;

    // Priority pick: lowest valid index at/above ptr, else lowest valid
    // overall (the wrap-around case). The second loop overrides the first
    // whenever the upper window has any candidate.
    always_comb begin
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (masked_valid[i]) begin
                grant_idx = IDW'(i);
            end
        end
    end

    // One-hot form of the chosen index
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_idx == IDW'(gi));
        end
    endgenerate

    // The requester just served moves to lowest priority
    assign ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // A grant is only issued from IDLE and never while reset is asserted
    assign grant_fire = (state_reg == ST_IDLE) && !rst && any_valid;

    assign calc_end    = (x_reg == y_reg) || (x_reg == '0) || (y_reg == '0);
    assign x_gt_y      = (x_reg > y_reg);
    assign calc_result = (x_reg == '0) ? y_reg : x_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant_fire) begin
                    req_ready  = grant_onehot;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (calc_end) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, subtraction steps, result and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            result_reg <= '0;
            id_reg     <= '0;
            ptr_reg    <= '0;
        end else begin
            if (grant_fire) begin
                x_reg   <= a_arr[grant_idx];
                y_reg   <= b_arr[grant_idx];
                id_reg  <= grant_idx;
                ptr_reg <= ptr_next;
            end else if (state_reg == ST_CALC) begin
                if (calc_end) begin
                    result_reg <= calc_result;
                end else if (x_gt_y) begin
                    x_reg <= x_reg - y_reg;
                end else begin
                    y_reg <= y_reg - x_reg;
                end
            end
        end
    end

    assign rsp_gcd = result_reg;
    assign rsp_id  = id_reg;

`ifdef GCD_ARB_STEP_CNT_EN
    logic [WIDTH-1:0] cnt_reg;

    // Step counter: clears on grant, counts subtracting CALC cycles, saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (grant_fire) begin
            cnt_reg <= '0;
        end else if ((state_reg == ST_CALC) && !calc_end && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + WIDTH'(1);
        end
    end

    assign rsp_cycles = cnt_reg;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed testbench for gcd_arbiter: reset, single requests, edge operands,
// round-robin order, response backpressure and reset during a calculation.
// Covers the rsp_cycles output as well when GCD_ARB_STEP_CNT_EN is defined.

module tb_gcd_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [WIDTH-1:0]      rsp_gcd;
    logic [IDW-1:0]        rsp_id;
`ifdef GCD_ARB_STEP_CNT_EN
    logic [WIDTH-1:0]      rsp_cycles;
`endif
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    gcd_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_gcd    (rsp_gcd),
        .rsp_id     (rsp_id),
`ifdef GCD_ARB_STEP_CNT_EN
        .rsp_cycles (rsp_cycles),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id] = 1'b1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Wait for a grant, check who got it, then wait for and check the response.
    // Called shortly after a posedge (or at a negedge); returns just after the
    // response handshake edge, with the DUT back in IDLE.
    task automatic serve(input int exp_id, input logic [WIDTH-1:0] exp_gcd,
                         input int exp_lat, input int exp_cyc, input string name);
        int n;
        int g;
        int lat;
        logic [NREQ-1:0] exp_grant;
        exp_grant = '0;
        exp_grant[exp_id] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== exp_grant) begin
            failures++;
            $display("FAIL %s_grant: req_ready=%b expected %b", name, req_ready, exp_grant);
        end
        if (req_ready == '0) begin
            return;
        end
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) g = i;
        end
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: rsp_valid=%b expected 1 within 300 cycles", name, rsp_valid);
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (rsp_gcd !== exp_gcd) begin
            failures++;
            $display("FAIL %s_gcd: got %0d expected %0d", name, rsp_gcd, exp_gcd);
        end
        checks++;
        if (rsp_id !== IDW'(exp_id)) begin
            failures++;
            $display("FAIL %s_id: got %0d expected %0d", name, rsp_id, exp_id);
        end
`ifdef GCD_ARB_STEP_CNT_EN
        checks++;
        if (rsp_cycles !== WIDTH'(exp_cyc)) begin
            failures++;
            $display("FAIL %s_cycles: got %0d expected %0d", name, rsp_cycles, exp_cyc);
        end
`endif
        $display("txn %s: id=%0d gcd=%0d latency=%0d (expected steps %0d)", name, rsp_id, rsp_gcd, lat, exp_cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 12, 8);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
                rsp_gcd !== '0 || rsp_id !== '0) begin
                failures++;
                $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b busy=%b rsp_gcd=%0d rsp_id=%0d expected all zero",
                         req_ready, rsp_valid, busy, rsp_gcd, rsp_id);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // (12,8): 4,8 -> 4,4 : two steps
        serve(0, 4, 4, 2, "reset_first_grant");
        req_valid = '0;
    endtask

    task automatic test_single();
        int          ids [7]  = '{1, 1, 2, 3, 0, 1, 2};
        logic [31:0] av  [7]  = '{48, 8, 0, 9, 0, 65, 90};
        logic [31:0] bv  [7]  = '{12, 2, 7, 0, 0, 65, 86};
        logic [31:0] gv  [7]  = '{12, 2, 7, 9, 0, 65, 2};
        int          lv  [7]  = '{5, 5, 2, 2, 2, 2, 25};
        int          cv  [7]  = '{3, 3, 0, 0, 0, 0, 23};
        for (int k = 0; k < 7; k++) begin
            set_req(ids[k], av[k], bv[k]);
            serve(ids[k], gv[k], lv[k], cv[k], "single");
        end
    endtask

    task automatic test_arbitration();
        apply_reset();
        set_req(0, 90, 86);
        set_req(1, 65, 4);
        set_req(2, 125, 6);
        set_req(3, 85, 76);
        serve(0, 2, 25, 23, "arb_r0");
        serve(1, 1, 21, 19, "arb_r1");
        serve(2, 1, 27, 25, "arb_r2");
        serve(3, 1, 16, 14, "arb_r3");
        set_req(0, 21, 14);
        set_req(2, 36, 24);
        serve(0, 7, 4, 2, "arb_pair_r0");
        serve(2, 12, 4, 2, "arb_pair_r2");
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        set_req(1, 54, 44);
        #1;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: req_ready=%b expected 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        set_req(2, 8, 2);
        n = 1;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL bp_latency: got %0d expected 10", n);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_gcd !== 32'd2 || rsp_id !== 2'd1 ||
                busy !== 1'b1 || req_ready !== '0) begin
                failures++;
                $display("FAIL bp_hold: rsp_valid=%b rsp_gcd=%0d rsp_id=%0d busy=%b req_ready=%b expected 1/2/1/1/0000",
                         rsp_valid, rsp_gcd, rsp_id, busy, req_ready);
            end
        end
        $display("txn backpressure: id=%0d gcd=%0d held for 10 cycles", rsp_id, rsp_gcd);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            failures++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 1/0000", rsp_valid, req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_grant: req_ready=%b busy=%b rsp_valid=%b expected 0100/0/0",
                     req_ready, busy, rsp_valid);
        end
        serve(2, 2, 5, 3, "bp_follow");
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        set_req(1, 109, 91);
        #1;
        n = 0;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_grant: req_ready=%b expected 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy_after_reset: got %b expected 0", busy);
        end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_no_response: rsp_valid seen %0d cycles expected 0", seen);
        end
        $display("txn reset_mid: discarded request, rsp_valid cycles=%0d", seen);
        @(posedge clk);
        #1;
        // With ptr back at 0, requester 0 wins over requester 3
        set_req(0, 10, 4);
        set_req(3, 15, 10);
        serve(0, 2, 5, 3, "mid_after_r0");
        serve(3, 5, 4, 2, "mid_after_r3");
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
